// File: rtl/i2c_target_regfile.sv
// I2C target with a 128-byte register file: pointer-set writes with auto-increment,
// sequential reads, repeated START, and a write strobe bus mirroring memory updates.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StMack, StWaitStop
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  scl_q, sda_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  sr_q, sr_d;
  logic [6:0]  tx_q, tx_d;
  logic [6:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  mem_q [128];
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  shift_byte;
  logic [7:0]  rd_byte;

  // [0],[1] synchronize; [2] is the previous synchronized value for edge detection
  logic scl_rise, scl_fall, start_det, stop_det, sda_in;
  assign sda_in    = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];
  assign rd_byte   = mem_q[ptr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    shift_byte = {sr_q, sda_in};
    mem_wdata  = shift_byte;

    if (start_det) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
    end else if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      if (busy_q) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            sr_d  = shift_byte[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == StAddr) begin
                if (shift_byte[7:1] == DEV_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                end else begin
                  state_d = StWaitStop;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = shift_byte[6:0];
                state_d = StPtrAck;
              end else begin
                mem_we    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_byte;
                ptr_d     = ptr_q + 7'd1;
                state_d   = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          // First fall opens the ACK clock, the second one closes it
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d = 1'b0;
              if (state_q == StAddrAck && sr_q[0]) begin
                tx_d    = rd_byte[6:0];
                oe_d    = ~rd_byte[7];
                rd_en_d = 1'b1;
                cnt_d   = 4'd0;
                state_d = StRdata;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              oe_d    = 1'b0;
              ptr_d   = ptr_q + 7'd1;
              cnt_d   = 4'd0;
              state_d = StMack;
            end else begin
              oe_d  = ~tx_q[6];
              tx_d  = {tx_q[5:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        StMack: begin
          // cnt_q marks that the master ACKed on this clock
          if (scl_rise) begin
            if (sda_in) state_d = StWaitStop;
            else        cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q != 4'd0) begin
            cnt_d   = 4'd0;
            tx_d    = rd_byte[6:0];
            oe_d    = ~rd_byte[7];
            rd_en_d = 1'b1;
            state_d = StRdata;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      sr_q      <= 7'd0;
      tx_q      <= 7'd0;
      ptr_q     <= 7'd0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 8'd0;
    end else begin
      scl_q     <= {scl_q[1:0], scl};
      sda_q     <= {sda_q[1:0], sda};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) mem_q[i] <= 8'(i);
    end else if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  assign sda     = oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_en   = rd_en_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, register-file model,
// and a per-cycle monitor matching write strobes against expected writes.
module tb_i2c_target_regfile;
  localparam int Q = 8;
  localparam logic [6:0] Dev = 7'h50;
  typedef logic [7:0] bytes_t[$];

  logic clk, rst, scl_drv, m_sda_low;
  wire  sda;
  logic busy, done, wr_en, rd_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_target_regfile #(.DEV_ADDR(Dev)) dut (
    .clk(clk), .rst(rst), .scl(scl_drv), .sda(sda), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  logic [7:0]  mem_m [128];
  logic [6:0]  ptr_m;
  logic [14:0] exp_wr[$];
  logic [6:0]  wr_log[$];
  logic [14:0] cmp_e;
  logic        wr_en_prev;
  int rd_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mem_m[i] = 8'(i);
    ptr_m = 7'd0;
  endtask

  // Every-cycle monitor: each wr_en must match the next expected write
  always @(negedge clk) begin
    if (!rst) begin
      wr_en_prev <= 1'b0;
    end else begin
      if (wr_en) begin
        check("wr_en_width", 32'(wr_en_prev), 32'd0);
        if (exp_wr.size() == 0) begin
          check("wr_en_unexpected", 32'(wr_en), 32'd0);
        end else begin
          cmp_e = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(cmp_e[14:8]));
          check("wr_data", 32'(wr_data), 32'(cmp_e[7:0]));
        end
        wr_log.push_back(wr_addr);
      end
      if (rd_en) rd_cnt++;
      if (done) done_cnt++;
      wr_en_prev <= wr_en;
    end
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b1; qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0; qwait();
    scl_drv = 1'b1; qwait();
    m_sda_low = 1'b1; qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; qwait();
    scl_drv = 1'b1; qwait();
    m_sda_low = 1'b0; qwait();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda_low = ~b; qwait();
    scl_drv = 1'b1; qwait();
    s = sda; qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(~mack, s);
  endtask

  task automatic txn_write(input logic [6:0] p, input bytes_t data);
    logic ack;
    int d0;
    d0 = done_cnt;
    bus_start();
    send_byte({Dev, 1'b0}, ack); check("addr_ack_w", 32'(ack), 32'd1);
    send_byte({1'b0, p}, ack);   check("ptr_ack", 32'(ack), 32'd1);
    ptr_m = p;
    foreach (data[i]) begin
      exp_wr.push_back({ptr_m, data[i]});
      mem_m[ptr_m] = data[i];
      ptr_m++;
      send_byte(data[i], ack); check("data_ack", 32'(ack), 32'd1);
    end
    check("busy_in_write", 32'(busy), 32'd1);
    bus_stop();
    check("busy_after_write", 32'(busy), 32'd0);
    check("done_write", 32'(done_cnt - d0), 32'd1);
    check("wr_pending", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic txn_read(input logic set_ptr, input logic [6:0] p, input int n,
                          output bytes_t got);
    logic ack;
    logic [7:0] d;
    int d0, r0;
    d0 = done_cnt;
    r0 = rd_cnt;
    got = {};
    bus_start();
    if (set_ptr) begin
      send_byte({Dev, 1'b0}, ack); check("addr_ack_w", 32'(ack), 32'd1);
      send_byte({1'b0, p}, ack);   check("ptr_ack", 32'(ack), 32'd1);
      ptr_m = p;
      bus_rstart();
      check("busy_rstart", 32'(busy), 32'd1);
    end
    send_byte({Dev, 1'b1}, ack); check("addr_ack_r", 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      read_byte(k != n - 1, d);
      check("rd_data", 32'(d), 32'(mem_m[ptr_m]));
      got.push_back(d);
      ptr_m++;
    end
    bus_stop();
    check("busy_after_read", 32'(busy), 32'd0);
    check("done_read", 32'(done_cnt - d0), 32'd1);
    check("rd_en_count", 32'(rd_cnt - r0), 32'(n));
  endtask

  task automatic txn_nomatch(input logic [6:0] a);
    logic ack;
    int d0;
    d0 = done_cnt;
    bus_start();
    send_byte({a, 1'b0}, ack); check("nomatch_addr_ack", 32'(ack), 32'd0);
    check("nomatch_busy", 32'(busy), 32'd0);
    send_byte(8'hFF, ack);     check("nomatch_data_ack", 32'(ack), 32'd0);
    bus_stop();
    check("nomatch_done", 32'(done_cnt - d0), 32'd0);
  endtask

  task automatic dut_reset();
    scl_drv = 1'b1;
    m_sda_low = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    rst = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bytes_t got, data;
    logic ack;
    rst = 1'b0;
    scl_drv = 1'b1;
    m_sda_low = 1'b0;
    model_reset();
    dut_reset();

    // Reset contents
    txn_read(1'b1, 7'h00, 4, got);
    for (int i = 0; i < 4; i++) check("reset_content", 32'(got[i]), 32'(i));

    // Reset while the target drives a 0 data bit (mem[0] = 0x00)
    bus_start();
    send_byte({Dev, 1'b0}, ack);
    send_byte(8'h00, ack);
    bus_rstart();
    send_byte({Dev, 1'b1}, ack);
    m_sda_low = 1'b0; qwait();
    scl_drv = 1'b1; qwait();
    check("mid_read_drive", 32'(sda), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_read_release", 32'(sda), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    scl_drv = 1'b0; qwait();
    bus_stop();
    txn_read(1'b1, 7'h05, 1, got);
    check("after_reset_read", 32'(got[0]), 32'h05);

    // Write then read back
    wr_log = {};
    txn_write(7'h10, '{8'h5A, 8'hC3});
    check("wr_addr_0", 32'(wr_log[0]), 32'h10);
    check("wr_addr_1", 32'(wr_log[1]), 32'h11);
    txn_read(1'b0, 7'h00, 1, got);
    check("ptr_after_write", 32'(got[0]), 32'h12);
    txn_read(1'b1, 7'h10, 2, got);
    check("readback_0", 32'(got[0]), 32'h5A);
    check("readback_1", 32'(got[1]), 32'hC3);

    // Address mismatch
    txn_nomatch(7'h58);

    // Pointer wrap
    wr_log = {};
    txn_write(7'h7F, '{8'h11, 8'h22});
    check("wrap_addr_0", 32'(wr_log[0]), 32'h7F);
    check("wrap_addr_1", 32'(wr_log[1]), 32'h00);
    txn_read(1'b1, 7'h7F, 2, got);
    check("wrap_read_0", 32'(got[0]), 32'h11);
    check("wrap_read_1", 32'(got[1]), 32'h22);

    // Randomized traffic against the model
    for (int it = 0; it < 14; it++) begin
      int op, n;
      logic [6:0] a;
      op = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 4));
      if (op <= 1) begin
        data = {};
        for (int k = 0; k < n; k++) data.push_back(8'($urandom));
        txn_write(7'($urandom), data);
      end else if (op == 2) begin
        txn_read(1'($urandom), 7'($urandom), n, got);
      end else begin
        a = 7'($urandom);
        if (a == Dev) a = a ^ 7'h01;
        txn_nomatch(a);
      end
    end

    check("wr_pending_end", 32'(exp_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
